// File: rtl/io_frame_adapter_if.sv
// rtl/io_frame_adapter_if.sv - stream, core and status signals of the frame adapter
interface io_frame_adapter_if #(
    parameter int DATA_W    = 64,
    parameter int IN_BEATS  = 12,
    parameter int OUT_BEATS = 8,
    parameter int CNT_W     = 16
);
    logic                          i_in_valid;
    logic                          o_in_ready;
    logic [DATA_W-1:0]             i_in_data;
    logic                          o_core_start;
    logic [IN_BEATS*DATA_W-1:0]    o_core_data;
    logic                          i_core_done;
    logic [OUT_BEATS*DATA_W-1:0]   i_core_result;
    logic                          o_out_valid;
    logic                          i_out_ready;
    logic [DATA_W-1:0]             o_out_data;
    logic                          o_busy;
    logic [CNT_W-1:0]              o_frame_cnt;

    modport slave (
        input  i_in_valid, i_in_data, i_core_done, i_core_result, i_out_ready,
        output o_in_ready, o_core_start, o_core_data, o_out_valid, o_out_data,
               o_busy, o_frame_cnt
    );

    modport master (
        output i_in_valid, i_in_data, i_core_done, i_core_result, i_out_ready,
        input  o_in_ready, o_core_start, o_core_data, o_out_valid, o_out_data,
               o_busy, o_frame_cnt
    );
endinterface

// File: rtl/io_frame_adapter.sv
// rtl/io_frame_adapter.sv - gathers input beats into a core operand frame and serializes the core result
module io_frame_adapter #(
    parameter int DATA_W    = 64,
    parameter int IN_BEATS  = 12,
    parameter int OUT_BEATS = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    io_frame_adapter_if.slave bus
);
    localparam int IN_CW  = (IN_BEATS  > 1) ? $clog2(IN_BEATS)  : 1;
    localparam int OUT_CW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

    typedef enum logic [1:0] {S_IN, S_CORE, S_OUT} state_e;

    state_e              state_q, state_d;
    logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
    logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0]   core_q [IN_BEATS];
    logic [DATA_W-1:0]   core_d [IN_BEATS];
    logic [DATA_W-1:0]   obuf_q [OUT_BEATS];
    logic [DATA_W-1:0]   obuf_d [OUT_BEATS];
    logic [DATA_W-1:0]   res_slice [OUT_BEATS];
    logic                in_ready_q, in_ready_d;
    logic                start_q, start_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [IN_CW-1:0]    in_slot;
    logic [OUT_CW-1:0]   out_slot;
    logic                in_fire;
    logic                out_fire;

    // Beat order onto slices: MSB_FIRST walks the frame from the top slice down.
    assign in_slot  = (MSB_FIRST != 0) ? (IN_LAST - in_cnt_q)   : in_cnt_q;
    assign out_slot = (MSB_FIRST != 0) ? (OUT_LAST - out_cnt_q) : out_cnt_q;
    assign in_fire  = bus.i_in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.i_out_ready;

    for (genvar g = 0; g < OUT_BEATS; g++) begin : g_res
        assign res_slice[g] = bus.i_core_result[g*DATA_W +: DATA_W];
    end

    for (genvar g = 0; g < IN_BEATS; g++) begin : g_core
        assign bus.o_core_data[g*DATA_W +: DATA_W] = core_q[g];
    end

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        core_d      = core_q;
        obuf_d      = obuf_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = 1'b0;
        case (state_q)
            S_IN: begin
                if (in_fire) begin
                    core_d[in_slot] = bus.i_in_data;
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = S_CORE;
                        start_d  = 1'b1;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_CORE: begin
                if (bus.i_core_done) begin
                    obuf_d  = res_slice;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d   = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = S_IN;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IN;
        endcase
        // Status flags are registered copies of the next state so every output leaves a flop.
        in_ready_d  = (state_d == S_IN);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IN;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            core_q      <= '{default: '0};
            obuf_q      <= '{default: '0};
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            core_q      <= core_d;
            obuf_q      <= obuf_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.o_in_ready   = in_ready_q;
    assign bus.o_core_start = start_q;
    assign bus.o_out_valid  = out_valid_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_cnt  = frame_cnt_q;
    assign bus.o_out_data   = obuf_q[out_slot];
endmodule

// File: tb/tb_io_frame_adapter.sv
// tb/tb_io_frame_adapter.sv - directed bench driving an MSB-first and an LSB-first adapter in lockstep
module tb_io_frame_adapter;
    localparam int DW = 64;
    localparam int NI = 12;
    localparam int NO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic [DW-1:0] beats [NI];
    logic [DW-1:0] res   [NO];

    io_frame_adapter_if #(.DATA_W(DW), .IN_BEATS(NI), .OUT_BEATS(NO), .CNT_W(16)) bus_m ();
    io_frame_adapter_if #(.DATA_W(DW), .IN_BEATS(NI), .OUT_BEATS(NO), .CNT_W(2))  bus_l ();

    io_frame_adapter #(.DATA_W(DW), .IN_BEATS(NI), .OUT_BEATS(NO), .MSB_FIRST(1), .CNT_W(16)) dut_m (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_m)
    );

    io_frame_adapter #(.DATA_W(DW), .IN_BEATS(NI), .OUT_BEATS(NO), .MSB_FIRST(0), .CNT_W(2)) dut_l (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_l)
    );

    assign bus_l.i_in_valid    = bus_m.i_in_valid;
    assign bus_l.i_in_data     = bus_m.i_in_data;
    assign bus_l.i_core_done   = bus_m.i_core_done;
    assign bus_l.i_core_result = bus_m.i_core_result;
    assign bus_l.i_out_ready   = bus_m.i_out_ready;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic rdy, input logic busy, input logic ov);
        check({tag, "_rdy_m"},  bus_m.o_in_ready,  rdy);
        check({tag, "_rdy_l"},  bus_l.o_in_ready,  rdy);
        check({tag, "_busy_m"}, bus_m.o_busy,      busy);
        check({tag, "_busy_l"}, bus_l.o_busy,      busy);
        check({tag, "_ov_m"},   bus_m.o_out_valid, ov);
        check({tag, "_ov_l"},   bus_l.o_out_valid, ov);
    endtask

    task automatic check_core(input string tag);
        for (int s = 0; s < NI; s++) begin
            check({tag, "_m"}, bus_m.o_core_data[(NI-1-s)*DW +: DW], beats[s]);
            check({tag, "_l"}, bus_l.o_core_data[s*DW +: DW], beats[s]);
        end
    endtask

    task automatic do_reset(input int n);
        bus_m.i_in_valid    = 1'b0;
        bus_m.i_in_data     = '0;
        bus_m.i_core_done   = 1'b0;
        bus_m.i_core_result = '0;
        bus_m.i_out_ready   = 1'b0;
        rst = 1'b1;
        repeat (n) tick();
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_start_m", bus_m.o_core_start, 0);
        check("rst_start_l", bus_l.o_core_start, 0);
        check("rst_cnt_m", bus_m.o_frame_cnt, 0);
        check("rst_cnt_l", bus_l.o_frame_cnt, 0);
        check("rst_core_m", |bus_m.o_core_data, 0);
        check("rst_core_l", |bus_l.o_core_data, 0);
        check("rst_out_m", bus_m.o_out_data, 0);
        rst = 1'b0;
        tick();
        check_flags("post_rst", 1'b1, 1'b0, 1'b0);
        exp_cnt = 0;
    endtask

    task automatic send_frame(input bit rnd);
        int k = 0;
        int guard = 0;
        bit v;
        while (k < NI && guard < 2000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_m.i_in_valid = v;
            bus_m.i_in_data  = beats[k];
            check_flags("in", 1'b1, 1'b0, 1'b0);
            tick();
            guard++;
            if (v) k++;
        end
        bus_m.i_in_valid = 1'b0;
        check("in_beats_accepted", k, NI);
        check("start_m", bus_m.o_core_start, 1);
        check("start_l", bus_l.o_core_start, 1);
        check_flags("core_entry", 1'b0, 1'b1, 1'b0);
        check_core("core");
    endtask

    task automatic run_core(input int delay, input bit junk);
        for (int c = 0; c < delay; c++) begin
            if (junk) begin
                bus_m.i_in_valid = 1'b1;
                bus_m.i_in_data  = '1;
            end
            check_flags("core_wait", 1'b0, 1'b1, 1'b0);
            if (c > 0) check("start_pulse_m", bus_m.o_core_start, 0);
            tick();
        end
        bus_m.i_in_valid  = 1'b0;
        bus_m.i_core_done = 1'b1;
        for (int j = 0; j < NO; j++) bus_m.i_core_result[j*DW +: DW] = res[j];
        tick();
        bus_m.i_core_done = 1'b0;
        check_flags("out_entry", 1'b0, 1'b1, 1'b1);
        check("start_low_m", bus_m.o_core_start, 0);
        check_core("core_hold");
    endtask

    task automatic drain(input bit rnd);
        int m = 0;
        int guard = 0;
        bit r;
        logic [DW-1:0] pm, pl;
        while (m < NO && guard < 2000) begin
            check("out_valid_m", bus_m.o_out_valid, 1);
            check("out_valid_l", bus_l.o_out_valid, 1);
            check("out_m", bus_m.o_out_data, res[NO-1-m]);
            check("out_l", bus_l.o_out_data, res[m]);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_m.i_out_ready = r;
            pm = bus_m.o_out_data;
            pl = bus_l.o_out_data;
            tick();
            guard++;
            if (r) begin
                m++;
            end else begin
                check("stall_m", bus_m.o_out_data, pm);
                check("stall_l", bus_l.o_out_data, pl);
            end
        end
        bus_m.i_out_ready = 1'b0;
        check("out_beats_sent", m, NO);
        exp_cnt++;
        check("frame_cnt_m", bus_m.o_frame_cnt, 64'(exp_cnt % 65536));
        check("frame_cnt_l", bus_l.o_frame_cnt, 64'(exp_cnt % 4));
        check_flags("back_to_in", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        do_reset(2);

        // Descending beats, stepped result, input held off during the core phase
        for (int k = 0; k < NI; k++) beats[k] = 64'(11 - k);
        for (int j = 0; j < NO; j++) res[j] = 64'(8'h11 * j);
        send_frame(1'b0);
        run_core(5, 1'b1);
        drain(1'b0);

        // Ascending beats, done arriving in the same cycle as start
        for (int k = 0; k < NI; k++) beats[k] = 64'(k);
        for (int j = 0; j < NO; j++) res[j] = 64'(8'h10 + j);
        send_frame(1'b0);
        run_core(0, 1'b0);
        drain(1'b0);

        // Three more frames to walk the 2-bit counter through its wrap
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NI; k++) beats[k] = {$urandom, $urandom};
            for (int j = 0; j < NO; j++) res[j] = {$urandom, $urandom};
            send_frame(1'b0);
            run_core(1, 1'b0);
            drain(1'b0);
        end

        // Partial frame discarded by reset, stray done in S_IN ignored
        for (int k = 0; k < 5; k++) begin
            bus_m.i_in_valid = 1'b1;
            bus_m.i_in_data  = 64'hDEAD_0000 + 64'(k);
            tick();
        end
        do_reset(1);
        for (int j = 0; j < NO; j++) bus_m.i_core_result[j*DW +: DW] = 64'hBAD0 + 64'(j);
        bus_m.i_core_done = 1'b1;
        tick();
        bus_m.i_core_done = 1'b0;
        check_flags("done_in_idle", 1'b1, 1'b0, 1'b0);
        tick();
        check_flags("done_in_idle2", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < NI; k++) beats[k] = 64'hA000 + 64'(k);
        for (int j = 0; j < NO; j++) res[j] = 64'hC000 + 64'(j);
        send_frame(1'b0);
        run_core(2, 1'b0);
        drain(1'b0);

        // Twenty frames with random valid, ready and core latency
        do_reset(1);
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NI; k++) beats[k] = {$urandom, $urandom};
            for (int j = 0; j < NO; j++) res[j] = {$urandom, $urandom};
            send_frame(1'b1);
            run_core($urandom_range(0, 3), 1'b0);
            drain(1'b1);
        end
        check("frame_cnt_20_m", bus_m.o_frame_cnt, 20);
        check("frame_cnt_20_l", bus_l.o_frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_frame_adapter.md
IO_FRAME_ADAPTER -- requirements
Module: io_frame_adapter

Interface
REQ-001 Parameter DATA_W, default 64: width of one stream beat on both input and output.
REQ-002 Parameter IN_BEATS, default 12: input beats per frame (3 x 256-bit operands at 64 bits per beat).
REQ-003 Parameter OUT_BEATS, default 8: output beats per frame (2 x 256-bit results).
REQ-004 Parameter MSB_FIRST, default 1: 1 = first beat maps to the most-significant slice; 0 = first beat maps to slice 0.
REQ-005 Parameter CNT_W, default 16: width of the completed-frame counter.
REQ-006 i_clk  input  1  single clock; all logic on the rising edge.
REQ-007 i_rst  input  1  reset, synchronous, active-high.
REQ-008 i_in_valid  input  1  input beat valid.
REQ-009 o_in_ready  output  1  adapter accepts an input beat.
REQ-010 i_in_data  input  DATA_W  input beat.
REQ-011 o_core_start  output  1  one-cycle pulse telling the core that o_core_data is complete.
REQ-012 o_core_data  output  IN_BEATS*DATA_W  assembled input frame.
REQ-013 i_core_done  input  1  one-cycle pulse; i_core_result is valid in this cycle.
REQ-014 i_core_result  input  OUT_BEATS*DATA_W  core result.
REQ-015 o_out_valid  output  1  output beat valid.
REQ-016 i_out_ready  input  1  downstream accepts an output beat.
REQ-017 o_out_data  output  DATA_W  output beat.
REQ-018 o_busy  output  1  high in S_CORE and S_OUT.
REQ-019 o_frame_cnt  output  CNT_W  number of fully delivered frames, modulo 2^CNT_W.

Function
REQ-020 The FSM SHALL have three states: S_IN (collect), S_CORE (core running), S_OUT (serialize).
REQ-021 Input and output transfers SHALL occur only on cycles where valid and ready are both high at the clock edge.
REQ-022 In S_IN, o_in_ready SHALL be 1 and o_out_valid SHALL be 0; o_in_ready SHALL be 0 in every other state.
REQ-023 Beat k of a frame (k = 0..IN_BEATS-1) SHALL be stored in slice IN_BEATS-1-k when MSB_FIRST=1, and in slice k when MSB_FIRST=0.
REQ-024 Accepting beat IN_BEATS-1 SHALL move the FSM to S_CORE on the same edge; o_core_start SHALL be 1 for exactly the first S_CORE cycle.
REQ-025 o_core_data SHALL hold constant from entry to S_CORE until the next frame's first beat is accepted.
REQ-026 i_core_done SHALL be acted on only in S_CORE; it is ignored in S_IN and S_OUT. A done that coincides with the o_core_start cycle SHALL be accepted.
REQ-027 On an accepted done, i_core_result SHALL be captured into the output buffer and the FSM SHALL enter S_OUT on the next edge.
REQ-028 In S_OUT, o_out_valid SHALL be 1 and o_out_data SHALL be output slice OUT_BEATS-1-m (MSB_FIRST=1) or slice m (MSB_FIRST=0), where m is the count of beats already sent.
REQ-029 While i_out_ready=0, o_out_data and o_out_valid SHALL stay stable; stall length is unbounded.
REQ-030 Accepting output beat OUT_BEATS-1 SHALL: return the FSM to S_IN, clear the beat counters, and increment o_frame_cnt, with wrap from 2^CNT_W-1 to 0. o_in_ready SHALL rise in the next cycle, with no idle bubble beyond that cycle.
REQ-031 Beat counters SHALL be ceil(log2) sized and SHALL never exceed IN_BEATS-1 or OUT_BEATS-1.
REQ-032 Input data beyond a frame boundary SHALL be back-pressured (o_in_ready=0), not dropped or overwritten.
REQ-033 All outputs SHALL be driven directly from registers, except o_out_data, which is a multiplexer of registered slices.

Reset
REQ-034 While i_rst=1 at an edge, the FSM SHALL go to S_IN, counters SHALL go to 0, o_core_data and the output buffer SHALL be zeroed, and o_frame_cnt SHALL be 0.
REQ-035 While i_rst is asserted, o_in_ready, o_core_start, o_out_valid and o_busy SHALL be 0; o_in_ready SHALL be 1 on the first cycle after i_rst falls.
REQ-036 Reset asserted in any state, including mid-frame or mid-output, SHALL discard the partial frame; the next accepted beat SHALL be beat 0.

Verification
REQ-037 Defaults, MSB_FIRST=1, 12 beats 0x0B..0x00 with valid held high -> o_core_data = {0x0B,...,0x00} per 64-bit slice; o_core_start high exactly 1 cycle, on the cycle after beat 12 is accepted.
REQ-038 Core model returns done 5 cycles after start with result slices 7..0 = 0x77..0x00, out_ready held high -> 8 consecutive output beats 0x77, 0x66, ..., 0x00; o_frame_cnt goes 0->1; o_in_ready high on the next cycle.
REQ-039 Random valid and random out_ready with 50% duty over 20 frames -> every frame is bit-exact against the model; o_out_data never changes while it is stalled; o_frame_cnt=20.
REQ-040 MSB_FIRST=0, input beats 0..11 -> slice k = k; result slices k = 0x10+k are output in order 0x10..0x17.
REQ-041 i_rst pulsed after 5 input beats, then a full 12-beat frame -> core data contains only the new frame; a done pulse in S_IN is ignored (no transition to S_OUT).
REQ-042 CNT_W=2, 5 frames -> o_frame_cnt sequence 1, 2, 3, 0, 1.
